sprite_spawner: RTL

SPRITE_SPAWNER -- requirements
Module: sprite_spawner

---
 rtl/spawner_pkg.sv | 30 +++
 rtl/lfsr16_galois.sv | 16 +
 rtl/sprite_spawner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spawner_pkg.sv
// Shared types and constants for the sprite spawner: FSM states, mode codes,
// LFSR feedback mask and the per-slot position record.
package spawner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_X,
    DRAW_Y,
    NEXT,
    WAIT_FRAME
  } spawn_state_t;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_RR     = 2'd2;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        sel;
  } sprite_pos_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// Free-running 16-bit maximal-length Galois LFSR; steps every clock, held at seed in reset.
module lfsr16_galois
  import spawner_pkg::*;
(
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
  input  logic [15:0] seed_in,
  output logic [15:0] q_out
);

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) q_out <= seed_in;
    else           q_out <= lfsr_step(q_out);
  end

endmodule

// File: rtl/sprite_spawner.sv
// Rejection-sampled random sprite placement; draws into a shadow set and
// publishes it tear-free on the frame boundary after generation completes.
module sprite_spawner
  import spawner_pkg::*;
#(
  parameter int          N_SPRITES   = 4,
  parameter int          H_ACTIVE    = 1280,
  parameter int          V_ACTIVE    = 720,
  parameter int          SPRITE_W    = 256,
  parameter int          SPRITE_H    = 256,
  parameter logic [15:0] SEED        = 16'h5555,
  parameter int          HOLD_FRAMES = 60,
  parameter int          MAX_TRIES   = 8
) (
  input  logic                        clk_pixel_in,
  input  logic                        rst_n_in,
  input  logic                        spawn_in,
  input  logic                        new_frame_in,
  input  logic [1:0]                  mode_in,
  output logic [N_SPRITES-1:0][10:0]  x_out,
  output logic [N_SPRITES-1:0][9:0]   y_out,
  output logic [N_SPRITES-1:0]        sel_out,
  output logic                        busy_out,
  output logic                        commit_out,
  output logic [7:0]                  spawn_cnt_out
);

  localparam int SLOT_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 2);
  localparam int FCNT_W = $clog2(HOLD_FRAMES + 2);

  localparam logic [10:0]       X_BOUND   = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]        Y_BOUND   = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SPRITES - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES);
  localparam logic [FCNT_W-1:0] HOLD_CNT  = FCNT_W'(HOLD_FRAMES);

  if (SPRITE_W > H_ACTIVE || SPRITE_H > V_ACTIVE) begin : g_bad_size
    $error("sprite_spawner: sprite does not fit inside the active area");
  end
  if (N_SPRITES < 1 || N_SPRITES > 8 || SEED == 16'h0000) begin : g_bad_cfg
    $error("sprite_spawner: N_SPRITES must be 1..8 and SEED nonzero");
  end

  spawn_state_t                 state, state_nxt;
  logic [15:0]                  lfsr;
  logic [SLOT_W-1:0]            slot, rr_ptr;
  logic [TRY_W-1:0]             tries;
  logic [FCNT_W-1:0]            fcnt;
  logic [1:0]                   mode_q;
  logic                         pend, gen_rr;
  sprite_pos_t [N_SPRITES-1:0]  shadow;

  logic trig, acc_x, acc_y, step_slot, commit_go;
  logic is_auto, is_rr, x_ok, y_ok, try_out;

  lfsr16_galois u_lfsr (
    .clk_pixel_in (clk_pixel_in),
    .rst_n_in     (rst_n_in),
    .seed_in      (SEED),
    .q_out        (lfsr)
  );

  // Mode 3 falls through to manual behaviour because only AUTO/RR are decoded
  assign is_auto  = (mode_in == MODE_AUTO);
  assign is_rr    = (mode_in == MODE_RR);
  assign x_ok     = (lfsr[10:0] <= X_BOUND);
  assign y_ok     = (lfsr[9:0]  <= Y_BOUND);
  assign try_out  = (tries == TRY_LAST);
  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    acc_x     = 1'b0;
    acc_y     = 1'b0;
    step_slot = 1'b0;
    commit_go = 1'b0;
    unique case (state)
      IDLE: begin
        trig = pend | (spawn_in & ~is_auto) | (is_auto & (fcnt == HOLD_CNT));
        if (trig) state_nxt = DRAW_X;
      end
      DRAW_X: if (x_ok || try_out) begin
        acc_x     = 1'b1;
        state_nxt = DRAW_Y;
      end
      DRAW_Y: if (y_ok || try_out) begin
        acc_y     = 1'b1;
        state_nxt = NEXT;
      end
      NEXT: begin
        if (gen_rr || slot == LAST_SLOT) begin
          state_nxt = WAIT_FRAME;
        end else begin
          step_slot = 1'b1;
          state_nxt = DRAW_X;
        end
      end
      WAIT_FRAME: if (new_frame_in) begin
        commit_go = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot          <= '0;
      rr_ptr        <= '0;
      tries         <= '0;
      fcnt          <= '0;
      mode_q        <= MODE_MANUAL;
      pend          <= 1'b0;
      gen_rr        <= 1'b0;
      shadow        <= '0;
      x_out         <= '0;
      y_out         <= '0;
      sel_out       <= '0;
      commit_out    <= 1'b0;
      spawn_cnt_out <= '0;
    end else begin
      mode_q     <= mode_in;
      commit_out <= commit_go;

      // Generation mode is frozen at trigger so mid-run mode changes wait for IDLE
      if (trig) begin
        slot   <= is_rr ? rr_ptr : '0;
        gen_rr <= is_rr;
      end else if (step_slot) begin
        slot <= slot + 1'b1;
      end

      if (trig || acc_x || acc_y)              tries <= '0;
      else if (state == DRAW_X || state == DRAW_Y) tries <= tries + 1'b1;

      if (acc_x) shadow[slot].x <= x_ok ? lfsr[10:0] : X_BOUND;
      if (acc_y) begin
        shadow[slot].y   <= y_ok ? lfsr[9:0] : Y_BOUND;
        shadow[slot].sel <= lfsr[15];
      end

      if (trig)                      pend <= 1'b0;
      else if (spawn_in && busy_out) pend <= 1'b1;

      if (trig || mode_in != mode_q)
        fcnt <= '0;
      else if (state == IDLE && is_auto && new_frame_in && fcnt != HOLD_CNT)
        fcnt <= fcnt + 1'b1;

      if (commit_go) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          x_out[i]   <= shadow[i].x;
          y_out[i]   <= shadow[i].y;
          sel_out[i] <= shadow[i].sel;
        end
        spawn_cnt_out <= spawn_cnt_out + 8'd1;
        if (gen_rr) rr_ptr <= (rr_ptr == LAST_SLOT) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

endmodule
